// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw asynchronous input and debounces it into a clean level, counting rejected glitches
//   clk          : rising-edge clock for all state
//   reset        : asynchronous active-low reset
//   din          : raw asynchronous input
//   clear_count  : synchronous clear of glitch_count, wins over a simultaneous increment
//   dout         : debounced level, changes only after STABLE_CYCLES agreeing samples
//   busy         : high while a candidate change is being qualified
//   glitch_count : saturating count of rejected candidate changes
module input_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       clear_count,
  output logic       dout,
  output logic       busy,
  output logic [7:0] glitch_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {STABLE, PENDING} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0] glitch_nxt;
  logic s, differ, reject, dout_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= {SYNC_STAGES{RESET_LEVEL}};
    else sync <= {sync[SYNC_STAGES-2:0], din};
  assign s = sync[SYNC_STAGES-1];
  assign differ = s != dout;
  // the counter holds how many consecutive samples have disagreed with dout so far
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    dout_nxt = dout;
    reject = 1'b0;
    if (state == STABLE) begin
      state_nxt = differ ? PENDING : STABLE;
      cnt_nxt = differ ? CW'(1) : '0;
    end else if (!differ) begin
      state_nxt = STABLE;
      reject = 1'b1;
    end else if (cnt < CW'(STABLE_CYCLES - 1)) begin
      cnt_nxt = cnt + CW'(1);
    end else begin
      state_nxt = STABLE;
      dout_nxt = s;
    end
  end
  assign glitch_nxt = clear_count ? 8'd0 :
                      (reject && glitch_count != 8'hFF) ? glitch_count + 8'd1 : glitch_count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= STABLE;
      cnt <= '0;
      dout <= RESET_LEVEL;
      busy <= 1'b0;
      glitch_count <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      dout <= dout_nxt;
      busy <= state_nxt == PENDING;
      glitch_count <= glitch_nxt;
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: table vectors, directed corner sequences and random stimulus against a run-length reference model
module tb_input_debouncer;
  localparam int SS = 2;
  localparam int SC = 4;
  logic clk = 0, reset = 1, din = 0, clear_count = 0;
  logic dout, busy;
  logic [7:0] glitch_count;
  int checks = 0, errors = 0;
  bit sq[$];
  bit md;
  int run, mg;
  typedef struct {bit d; bit clr; bit e_dout; bit e_busy; int e_g;} vec_t;
  vec_t tbl[18];
  always #5 clk = ~clk;
  input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .clear_count(clear_count),
    .dout(dout), .busy(busy), .glitch_count(glitch_count)
  );
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    sq = {};
    repeat (SS) sq.push_back(1'b0);
    md = 0;
    run = 0;
    mg = 0;
  endtask
  function automatic bit will_reject();
    return run > 0 && sq[0] == md;
  endfunction
  // sq is the synchronizer contents, oldest first; run counts consecutive samples disagreeing with dout
  task automatic step(bit d, bit clr);
    bit s;
    din = d;
    clear_count = clr;
    @(posedge clk);
    #1;
    s = sq.pop_front();
    sq.push_back(d);
    if (s != md) begin
      run++;
      if (run == SC) begin
        md = s;
        run = 0;
      end
    end else begin
      if (run > 0 && mg < 255) mg++;
      run = 0;
    end
    if (clr) mg = 0;
  endtask
  task automatic check_model(string tag);
    check({tag, "_dout"}, dout, md);
    check({tag, "_busy"}, busy, run > 0);
    check({tag, "_glitch"}, glitch_count, mg);
  endtask
  task automatic reset_now(string tag);
    reset = 0;
    #2;
    check({tag, "_rst_dout"}, dout, 0);
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_glitch"}, glitch_count, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1;
  endtask
  task automatic qualify(bit d, string tag);
    for (int i = 1; i <= 6; i++) begin
      step(d, 0);
      check({tag, "_lat"}, dout, (i == 6) ? d : !d);
    end
  endtask
  initial begin
    tbl = '{
      '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,1,0}, '{1,0,0,1,0}, '{1,0,0,1,0}, '{1,0,1,0,0},
      '{0,0,1,0,0}, '{0,0,1,0,0}, '{0,0,1,1,0}, '{0,0,1,1,0}, '{0,0,1,1,0}, '{0,0,0,0,0},
      '{1,0,0,0,0}, '{1,0,0,0,0}, '{0,0,0,1,0}, '{0,0,0,1,0}, '{0,0,0,0,1}, '{0,0,0,0,1}
    };
    // reset held with din=1, then a full qualification after release
    din = 1;
    #1 reset = 0;
    #11;
    check("hold_dout", dout, 0);
    check("hold_busy", busy, 0);
    check("hold_glitch", glitch_count, 0);
    model_reset();
    #4 reset = 1;
    qualify(1, "rel");
    check_model("rel");
    // fresh start with din low for the vector table
    din = 0;
    reset_now("pre_tbl");
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].d, tbl[i].clr);
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_glitch", i), glitch_count, tbl[i].e_g);
    end
    // bounce train of five short pulses, then settle high
    step(0, 1);
    check("bounce_clr", glitch_count, 0);
    begin
      int lens[5] = '{1, 3, 2, 1, 3};
      int n;
      for (int p = 0; p < 5; p++) begin
        repeat (lens[p]) begin
          step(1, 0);
          check("bounce_hold", dout, 0);
        end
        step(0, 0);
        check("bounce_hold", dout, 0);
      end
      n = 0;
      while (dout !== 1'b1 && n < 20) begin
        step(1, 0);
        n++;
      end
      check("bounce_latency", n, 6);
      check("bounce_glitch", glitch_count, 5);
      check_model("bounce");
    end
    // saturation, clear colliding with a rejection, then one more rejection
    step(1, 1);
    repeat (260) begin
      step(0, 0);
      step(1, 0);
    end
    step(1, 0);
    step(1, 0);
    check("sat_glitch", glitch_count, 255);
    check("sat_dout", dout, 1);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < 8 && !will_reject(); i++) step(1, 0);
    step(1, 1);
    check("clr_collide", glitch_count, 0);
    step(0, 0);
    repeat (4) step(1, 0);
    check("after_clr", glitch_count, 1);
    check_model("after_clr");
    // reset while dout is high drops it immediately
    reset_now("rst_high");
    qualify(1, "rst_high");
    // reset while a rising candidate is pending
    qualify(0, "fall");
    repeat (4) step(1, 0);
    check("mid_busy", busy, 1);
    reset_now("mid");
    qualify(1, "mid");
    // random runs against the reference model
    for (int i = 0; i < 600; i++) begin
      bit v = 1'($urandom_range(0, 1));
      int len = $urandom_range(1, 7);
      repeat (len) begin
        step(v, $urandom_range(0, 31) == 0);
        check_model("rand");
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
